// File: rtl/cr_rle_encoder.sv
// JPEG run/size/amplitude symbol encoder for one quantized 8x8 Cr block, with a one-block pending buffer.
// Optional: define CR_RLE_STATS_EN to add the sym_count output (symbols in the last completed block).
module cr_rle_encoder #(
    parameter int COEF_W = 11,
    parameter int AMP_W  = 12
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                enable,
    input  logic [7:0][7:0][COEF_W-1:0]         Q,
    output logic                                sym_valid,
    input  logic                                sym_ready,
    output logic                                sym_is_dc,
    output logic                                sym_eob,
    output logic [3:0]                          sym_run,
    output logic [3:0]                          sym_size,
    output logic [AMP_W-1:0]                    sym_amp,
    output logic                                block_done,
    output logic                                busy,
    output logic                                overflow
`ifdef CR_RLE_STATS_EN
    ,
    output logic [6:0]                          sym_count
`endif
);

    // Natural (row*8+col) position of each zigzag index.
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [1:0] {IDLE, DC, AC, EOB} state_t;

    state_t                    state;
    logic                      act_full;
    logic                      pend_full;
    logic signed [COEF_W-1:0]  act_buf  [64];
    logic signed [COEF_W-1:0]  pend_buf [64];
    logic signed [COEF_W-1:0]  zz_q     [64];
    logic signed [COEF_W-1:0]  prev_dc;
    logic signed [COEF_W-1:0]  cur_coef;
    logic [5:0]                idx;
    logic [5:0]                run;
    logic                      sym_last;
    logic                      accept;
    logic [AMP_W-1:0]          dc_diff;
    logic [AMP_W-1:0]          ac_val;
    logic [3:0]                dc_size;
    logic [3:0]                ac_size;
    logic [AMP_W-1:0]          dc_amp;
    logic [AMP_W-1:0]          ac_amp;

    function automatic logic [3:0] mag_size(input logic [AMP_W-1:0] v);
        logic [AMP_W-1:0] m;
        mag_size = '0;
        m = v[AMP_W-1] ? (~v + AMP_W'(1)) : v;
        for (int unsigned i = 0; i < AMP_W; i++) begin
            if (m[i]) mag_size = 4'(i + 1);
        end
    endfunction

    function automatic logic [AMP_W-1:0] mag_amp(input logic [AMP_W-1:0] v, input logic [3:0] size);
        logic [AMP_W-1:0] mask;
        mask = (AMP_W'(1) << size) - AMP_W'(1);
        mag_amp = v[AMP_W-1] ? ((v - AMP_W'(1)) & mask) : v;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < 64; i++) begin
            zz_q[i] = Q[ZZ[i][5:3]][ZZ[i][2:0]];
        end
        cur_coef = act_buf[idx];
        dc_diff  = AMP_W'(act_buf[0]) - AMP_W'(prev_dc);
        ac_val   = AMP_W'(cur_coef);
        dc_size  = mag_size(dc_diff);
        ac_size  = mag_size(ac_val);
        dc_amp   = mag_amp(dc_diff, dc_size);
        ac_amp   = mag_amp(ac_val, ac_size);
    end

    assign accept     = sym_valid & sym_ready;
    assign block_done = accept & sym_last;
    assign busy       = act_full;

    // A strobe coinciding with block_done lands in the active slot only when nothing is pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_full  <= 1'b0;
            pend_full <= 1'b0;
            overflow  <= 1'b0;
        end else if (block_done) begin
            if (pend_full) begin
                act_full  <= 1'b1;
                pend_full <= 1'b0;
                if (enable) overflow <= 1'b1;
            end else begin
                act_full <= enable;
            end
        end else if (enable) begin
            if (!act_full)       act_full  <= 1'b1;
            else if (!pend_full) pend_full <= 1'b1;
            else                 overflow  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (block_done && pend_full) begin
            act_buf <= pend_buf;
        end else if (enable && (block_done || !act_full)) begin
            act_buf <= zz_q;
        end
        if (enable && !block_done && act_full && !pend_full) begin
            pend_buf <= zz_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sym_valid <= 1'b0;
            sym_is_dc <= 1'b0;
            sym_eob   <= 1'b0;
            sym_run   <= '0;
            sym_size  <= '0;
            sym_amp   <= '0;
            sym_last  <= 1'b0;
            idx       <= '0;
            run       <= '0;
            prev_dc   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (act_full) begin
                        sym_valid <= 1'b1;
                        sym_is_dc <= 1'b1;
                        sym_eob   <= 1'b0;
                        sym_run   <= '0;
                        sym_size  <= dc_size;
                        sym_amp   <= dc_amp;
                        sym_last  <= 1'b0;
                        idx       <= 6'd1;
                        run       <= '0;
                        state     <= DC;
                    end
                end
                DC: begin
                    if (accept) begin
                        prev_dc   <= act_buf[0];
                        sym_valid <= 1'b0;
                        sym_is_dc <= 1'b0;
                        state     <= AC;
                    end
                end
                AC: begin
                    if (block_done) begin
                        sym_valid <= 1'b0;
                        sym_last  <= 1'b0;
                        state     <= IDLE;
                    end else if (!sym_valid || accept) begin
                        if (cur_coef == '0) begin
                            if (idx == 6'd63) begin
                                sym_valid <= 1'b1;
                                sym_eob   <= 1'b1;
                                sym_run   <= '0;
                                sym_size  <= '0;
                                sym_amp   <= '0;
                                sym_last  <= 1'b1;
                                state     <= EOB;
                            end else begin
                                sym_valid <= 1'b0;
                                idx       <= idx + 6'd1;
                                run       <= run + 6'd1;
                            end
                        end else if (run >= 6'd16) begin
                            // ZRL keeps the scan on the same index until the run fits in 4 bits.
                            sym_valid <= 1'b1;
                            sym_run   <= 4'd15;
                            sym_size  <= '0;
                            sym_amp   <= '0;
                            run       <= run - 6'd16;
                        end else begin
                            sym_valid <= 1'b1;
                            sym_run   <= run[3:0];
                            sym_size  <= ac_size;
                            sym_amp   <= ac_amp;
                            run       <= '0;
                            if (idx == 6'd63) sym_last <= 1'b1;
                            else              idx      <= idx + 6'd1;
                        end
                    end
                end
                EOB: begin
                    if (accept) begin
                        sym_valid <= 1'b0;
                        sym_eob   <= 1'b0;
                        sym_last  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CR_RLE_STATS_EN
    logic [6:0] sym_tally;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_tally <= '0;
            sym_count <= '0;
        end else if (accept) begin
            if (block_done) begin
                sym_count <= sym_tally + 7'd1;
                sym_tally <= '0;
            end else begin
                sym_tally <= sym_tally + 7'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cr_rle_encoder.sv
// Scoreboard bench for cr_rle_encoder: a zigzag/run-length reference model feeds a queue checked by a monitor.
module tb_cr_rle_encoder;
    localparam int COEF_W = 11;
    localparam int AMP_W  = 12;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        enable;
    logic [7:0][7:0][COEF_W-1:0] q;
    logic                        sym_valid, sym_ready, sym_is_dc, sym_eob;
    logic [3:0]                  sym_run, sym_size;
    logic [AMP_W-1:0]            sym_amp;
    logic                        block_done, busy, overflow;
`ifdef CR_RLE_STATS_EN
    logic [6:0]                  sym_count;
`endif

    always #5 clk = ~clk;

    cr_rle_encoder #(.COEF_W(COEF_W), .AMP_W(AMP_W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .Q(q),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_is_dc(sym_is_dc),
        .sym_eob(sym_eob), .sym_run(sym_run), .sym_size(sym_size), .sym_amp(sym_amp),
        .block_done(block_done), .busy(busy), .overflow(overflow)
`ifdef CR_RLE_STATS_EN
        , .sym_count(sym_count)
`endif
    );

    typedef struct packed {
        logic             is_dc;
        logic             eob;
        logic [3:0]       run;
        logic [3:0]       size;
        logic [AMP_W-1:0] amp;
        logic             last;
    } sym_t;

    sym_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   pushed = 0;
    int   done_cnt = 0;
    int   model_prev = 0;
    int   ready_mode = 1;     // 0: driven by main process, 1: always high, 2: random
    logic exp_overflow = 1'b0;

    function automatic int bitlen(input int m);
        int s = 0;
        while (m > 0) begin
            m = m >> 1;
            s++;
        end
        return s;
    endfunction

    function automatic sym_t mk(input bit is_dc, input bit eob, input int run, input int v);
        sym_t s;
        int   sz;
        int   a;
        sz = bitlen(v < 0 ? -v : v);
        a  = (v >= 0) ? v : v + (1 << sz) - 1;
        s.is_dc = is_dc;
        s.eob   = eob;
        s.run   = 4'(run);
        s.size  = 4'(sz);
        s.amp   = AMP_W'(a);
        s.last  = 1'b0;
        return s;
    endfunction

    task automatic model_block(input int b [8][8]);
        int   zr [64];
        int   zc [64];
        int   n = 0;
        int   run = 0;
        int   v;
        sym_t blk[$];
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin zr[n] = r; zc[n] = s - r; n++; end
            end else begin
                for (int r = lo; r <= hi; r++) begin zr[n] = r; zc[n] = s - r; n++; end
            end
        end
        blk.push_back(mk(1'b1, 1'b0, 0, b[0][0] - model_prev));
        model_prev = b[0][0];
        for (int k = 1; k < 64; k++) begin
            v = b[zr[k]][zc[k]];
            if (v == 0) begin
                run++;
            end else begin
                while (run >= 16) begin
                    blk.push_back(mk(1'b0, 1'b0, 15, 0));
                    run -= 16;
                end
                blk.push_back(mk(1'b0, 1'b0, run, v));
                run = 0;
            end
        end
        if (run > 0) blk.push_back(mk(1'b0, 1'b1, 0, 0));
        blk[blk.size() - 1].last = 1'b1;
        foreach (blk[i]) exp_q.push_back(blk[i]);
    endtask

    task automatic issue(input int b [8][8]);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                q[r][c] = COEF_W'(b[r][c]);
        enable = 1'b1;
        if (pushed - done_cnt < 2) begin
            model_block(b);
            pushed++;
        end else begin
            exp_overflow = 1'b1;
        end
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic wait_idle(input int max_cycles);
        int i = 0;
        while (!(exp_q.size() == 0 && pushed == done_cnt) && i < max_cycles) begin
            @(posedge clk); #1;
            i++;
        end
        if (exp_q.size() != 0 || pushed != done_cnt) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout got=%0d pending symbols want=0", exp_q.size());
            exp_q.delete();
            done_cnt = pushed;
        end else begin
            check("idle_busy", int'(busy), 0);
            check("idle_valid", int'(sym_valid), 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        #1;
        check("reset_outputs",
              int'({sym_valid, sym_is_dc, sym_eob, sym_run, sym_size, sym_amp, block_done, busy, overflow}), 0);
        exp_q.delete();
        pushed = 0;
        done_cnt = 0;
        model_prev = 0;
        exp_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic zero_block(output int b [8][8]);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = 0;
    endtask

    function automatic int rand_coef();
        int v;
        if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 2047)) - 1024;
        else                           v = int'($urandom_range(1, 7)) * ($urandom_range(0, 1) == 1 ? -1 : 1);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic rand_block(input int density, output int b [8][8]);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = ($urandom_range(0, density) == 0) ? rand_coef() : 0;
        b[0][0] = int'($urandom_range(0, 2047)) - 1024;
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 1)      sym_ready = 1'b1;
            else if (ready_mode == 2) sym_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        sym_t cur;
        sym_t snap;
        sym_t e;
        logic held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
                continue;
            end
            cur = {sym_is_dc, sym_eob, sym_run, sym_size, sym_amp, block_done};
            if (held) begin
                vectors++;
                if (!sym_valid || cur[AMP_W+9:1] !== snap[AMP_W+9:1]) begin
                    miscompares++;
                    $display("FAIL stall_hold got valid=%0b fields=%h want valid=1 fields=%h",
                             sym_valid, cur[AMP_W+9:1], snap[AMP_W+9:1]);
                end
            end
            if (sym_valid && sym_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_symbol got fields=%h want none", cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.last) done_cnt++;
                    if (cur !== e) begin
                        miscompares++;
                        $display("FAIL symbol got dc=%0b eob=%0b run=%0d size=%0d amp=%h done=%0b want dc=%0b eob=%0b run=%0d size=%0d amp=%h done=%0b",
                                 cur.is_dc, cur.eob, cur.run, cur.size, cur.amp, cur.last,
                                 e.is_dc, e.eob, e.run, e.size, e.amp, e.last);
                    end
                end
            end else if (block_done) begin
                vectors++;
                miscompares++;
                $display("FAIL done_without_accept got=1 want=0");
            end
            held = sym_valid && !sym_ready;
            snap = cur;
        end
    end

    initial begin
        int b [8][8];
        int guard;
        rst = 1'b1;
        enable = 1'b0;
        q = '0;
        sym_ready = 1'b0;
        #2;
        check("reset_outputs",
              int'({sym_valid, sym_is_dc, sym_eob, sym_run, sym_size, sym_amp, block_done, busy, overflow}), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // All-zero block and two-cycle latency to the DC symbol.
        ready_mode = 1;
        zero_block(b);
        issue(b);
        @(negedge clk);
        check("latency_cycle1_valid", int'(sym_valid), 0);
        check("latency_cycle1_busy", int'(busy), 1);
        @(negedge clk);
        check("latency_cycle2_valid", int'(sym_valid), 1);
        check("latency_cycle2_is_dc", int'(sym_is_dc), 1);
        wait_idle(300);

        // DC differential across two blocks.
        zero_block(b); b[0][0] = 5; issue(b); wait_idle(300);
        zero_block(b); b[0][0] = 3; issue(b); wait_idle(300);

        // ZRL followed by a short run at zigzag index 20.
        zero_block(b); b[5][0] = 1; issue(b); wait_idle(300);

        // Nonzero final coefficient: three ZRLs, no EOB.
        zero_block(b); b[7][7] = -1; issue(b); wait_idle(300);

        // Backpressure on the DC symbol, then on the -1024 AC symbol.
        ready_mode = 0;
        sym_ready = 1'b0;
        zero_block(b); b[0][1] = -1024; issue(b);
        repeat (6) begin @(posedge clk); #1; end
        sym_ready = 1'b1;
        @(posedge clk); #1;
        sym_ready = 1'b0;
        repeat (6) begin @(posedge clk); #1; end
        ready_mode = 1;
        wait_idle(300);

        // Randomised blocks and ready, never beyond the pending buffer.
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 30)) begin @(posedge clk); #1; end
            guard = 0;
            while (pushed - done_cnt >= 2 && guard < 2000) begin
                @(posedge clk); #1;
                guard++;
            end
            if (pushed - done_cnt >= 2) begin
                vectors++;
                miscompares++;
                $display("FAIL slot_timeout got=%0d outstanding want<2", pushed - done_cnt);
                exp_q.delete();
                done_cnt = pushed;
            end
            rand_block(int'($urandom_range(1, 12)), b);
            issue(b);
        end
        wait_idle(5000);
        check("overflow_clear", int'(overflow), int'(exp_overflow));

        // Three consecutive strobes: two blocks kept, the third dropped.
        ready_mode = 1;
        zero_block(b); b[0][0] = 10; b[0][1] = 2; issue(b);
        zero_block(b); b[0][0] = -20; b[2][2] = 7; issue(b);
        zero_block(b); b[0][0] = 300; issue(b);
        wait_idle(1000);
        check("overflow_set", int'(overflow), int'(exp_overflow));
        repeat (5) begin @(posedge clk); #1; end
        check("overflow_sticky", int'(overflow), 1);

        // Reset in the middle of AC scanning.
        ready_mode = 2;
        rand_block(1, b);
        issue(b);
        repeat (12) begin @(posedge clk); #1; end
        do_reset();
        check("overflow_after_rst", int'(overflow), 0);
        ready_mode = 1;
        zero_block(b); b[0][0] = 7; issue(b);
        wait_idle(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cr_rle_encoder.md
Name: cr_rle_encoder

Overview:
Consumes one quantized 8x8 Cr block (11-bit signed coefficients) from the Cr quantizer. Emits the block as a serial stream of JPEG run/size/amplitude symbols:
- DC differential first
- then zigzag-ordered AC run-lengths, with ZRL and EOB
It sits between the Cr quantizer and the Cr Huffman encoder, and absorbs downstream backpressure with a one-block pending buffer.

Parameters:
COEF_W, 11, coefficient width (two's complement)
AMP_W, 12, symbol amplitude field width; must be COEF_W+1

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
enable  in  1  one-cycle strobe; Q valid this cycle
Q  in  [8][8] x COEF_W  quantized block; Q[row][col], row = vertical frequency
sym_valid  out  1  symbol fields valid
sym_ready  in  1  downstream accepts symbol when sym_valid & sym_ready
sym_is_dc  out  1  symbol is the block's DC differential
sym_eob  out  1  symbol is EOB (run 0, size 0)
sym_run  out  4  zero run preceding the coefficient (0..15)
sym_size  out  4  magnitude category (0..12)
sym_amp  out  AMP_W  amplitude bits, right-aligned, upper bits zero
block_done  out  1  one-cycle pulse when the last symbol of a block is accepted
busy  out  1  active buffer occupied
overflow  out  1  sticky; strobe dropped because both buffers were full; cleared only by rst

Behaviour:
- Reset: every output is 0. prev_dc = 0, both buffers empty, FSM goes to IDLE.
- Reset mid-block discards all buffered data.
- Buffers:
  - enable with active buffer empty: capture Q into the active buffer.
  - enable with active buffer occupied: capture Q into the pending buffer.
  - Pending buffer is promoted to active in the cycle after block_done.
  - enable with both buffers full: block is dropped and overflow is set.
  - enable in the same cycle as block_done with a full pending buffer: counts as full, so the block is dropped.
- FSM states: IDLE, DC, AC, EOB.
  - IDLE -> DC when the active buffer is occupied.
  - DC -> AC when the DC symbol is accepted.
  - AC -> EOB after index 63 is scanned with run > 0.
  - AC -> IDLE after the index 63 symbol is accepted.
  - EOB -> IDLE when the EOB symbol is accepted.
- Latency: enable in cycle 0 (buffer empty, IDLE) gives sym_valid high in cycle 2 with the DC symbol.
- DC symbol:
  - diff = Q[0][0] - prev_dc, computed at 12-bit signed width.
  - prev_dc is updated to Q[0][0] when the DC symbol is accepted.
  - sym_run = 0.
- Size/amp rule:
  - size = bit length of |v|; size = 0 for v = 0.
  - amp = v for v >= 0.
  - amp = (v - 1) masked to the low size bits for v < 0.
- AC scan:
  - Standard JPEG zigzag over indices 1..63; index 1 = Q[0][1], index 2 = Q[1][0], index 20 = Q[5][0], index 63 = Q[7][7].
  - Zero coefficient: run++ and advance one index per cycle; no symbol is emitted.
  - Nonzero coefficient with run >= 16: emit ZRL (run 15, size 0, amp 0), run -= 16, stay on the same index.
  - Nonzero coefficient with run < 16: emit (run, size, amp), run = 0, advance.
- EOB is emitted only if trailing zeros remain. ZRLs are never emitted before an EOB.
- Handshake:
  - While sym_valid=1 and sym_ready=0, all sym_* fields hold stable and the scan stalls.
  - sym_valid never drops without acceptance.
  - Back-to-back symbols are allowed every cycle.
- block_done asserts in the cycle the final symbol (EOB, or the index-63 symbol) is accepted.
- busy is high from capture until that acceptance.

Optional Feature:
CR_RLE_STATS_EN:
- When defined, adds output sym_count (7 bits): number of symbols in the last completed block, including DC. It updates with block_done and resets to 0.
- When undefined, the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- All-zero block, prev_dc=0, sym_ready=1 -> DC (size 0, amp 0), EOB, block_done; sym_valid first high 2 cycles after enable.
- Block A with Q[0][0]=5, then block B with Q[0][0]=3, rest zero -> A: DC size 3, amp 101. B: DC diff -2, size 2, amp 01. Each followed by EOB.
- Only Q[5][0]=1 (index 20), DC 0 -> DC, ZRL (15/0), (run 3, size 1, amp 1), EOB.
- Only Q[7][7]=-1 -> DC, ZRL x3, (run 14, size 1, amp 0), no EOB; block_done on the last symbol.
- Q[0][1]=-1024, sym_ready held low 5 cycles -> fields stable (run 0, size 11, amp 0x3FF) until accepted.
- Three enables on consecutive cycles while the first block is streaming -> blocks 1 and 2 are emitted in order and block 3 is dropped. overflow=1 until rst.
- Assert rst mid-AC -> all outputs are 0 immediately; next block's DC diff uses prev_dc=0.
